// File: rtl/elastic_accum.sv
// Elastic accumulator: drains a valid/yumi register, emits per-group sums on valid/ready.
// Optional clamping of the running sum is enabled by defining ELASTIC_ACCUM_SATURATE_EN.
module elastic_accum #(
  parameter int width_p     = 10,
  parameter int count_p     = 4,
  parameter int sum_width_p = 12
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [width_p-1:0]     data_i,
  input  logic                   valid_i,
  output logic                   yumi_o,
  output logic                   valid_o,
  output logic [sum_width_p-1:0] data_o,
  input  logic                   ready_i
);

  localparam int cnt_w_lp = (count_p > 1) ? $clog2(count_p) : 1;
  localparam logic [cnt_w_lp-1:0] last_cnt_lp = cnt_w_lp'(count_p - 1);

  typedef enum logic {
    ACCUM,
    FULL
  } state_e;

  state_e                 state_q, state_d;
  logic [sum_width_p-1:0] acc_q, acc_d;
  logic [cnt_w_lp-1:0]    cnt_q, cnt_d;
  logic [sum_width_p-1:0] data_ext;
  logic [sum_width_p-1:0] sum;

  assign data_ext = sum_width_p'(data_i);

`ifdef ELASTIC_ACCUM_SATURATE_EN
  logic [sum_width_p:0] sum_full;
  assign sum_full = {1'b0, acc_q} + {1'b0, data_ext};
  assign sum      = sum_full[sum_width_p] ? '1 : sum_full[sum_width_p-1:0];
`else
  assign sum = acc_q + data_ext;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    yumi_o  = 1'b0;
    valid_o = 1'b0;
    unique case (state_q)
      ACCUM: begin
        yumi_o = valid_i;
        if (valid_i) begin
          acc_d = sum;
          if (cnt_q == last_cnt_lp) begin
            cnt_d   = '0;
            state_d = FULL;
          end else begin
            cnt_d = cnt_q + cnt_w_lp'(1);
          end
        end
      end
      FULL: begin
        valid_o = 1'b1;
        yumi_o  = valid_i & ready_i;
        if (ready_i) begin
          state_d = ACCUM;
          // Same-edge handoff: next group starts with this word.
          if (valid_i) begin
            acc_d = data_ext;
            cnt_d = cnt_w_lp'(1);
          end else begin
            acc_d = '0;
            cnt_d = '0;
          end
        end
      end
      default: state_d = ACCUM;
    endcase
    if (reset_i) begin
      yumi_o  = 1'b0;
      valid_o = 1'b0;
    end
  end

  assign data_o = reset_i ? '0 : acc_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_elastic_accum.sv
// Directed bench for elastic_accum with a queue of expected group totals.
// Also runs an overflow group on an 11-bit-sum instance.
module tb_elastic_accum;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [9:0]  data_i;
  logic        valid_i;
  logic        ready_i;
  logic        yumi_o;
  logic        valid_o;
  logic [11:0] data_o;

  logic [9:0]  data2;
  logic        valid2;
  logic        ready2;
  logic        yumi2;
  logic        valid_o2;
  logic [10:0] data_o2;

  int n_assert = 0;
  int n_fail   = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  elastic_accum u_dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .data_i  (data_i),
    .valid_i (valid_i),
    .yumi_o  (yumi_o),
    .valid_o (valid_o),
    .data_o  (data_o),
    .ready_i (ready_i)
  );

  elastic_accum #(
    .width_p     (10),
    .count_p     (4),
    .sum_width_p (11)
  ) u_ovf (
    .clk_i   (clk),
    .reset_i (reset_i),
    .data_i  (data2),
    .valid_i (valid2),
    .yumi_o  (yumi2),
    .valid_o (valid_o2),
    .data_o  (data_o2),
    .ready_i (ready2)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle; checks are taken 1 time unit after driving.
  task automatic step(input logic v, input int d, input logic r,
                      input logic ey, input logic ev);
    valid_i = v;
    data_i  = 10'(d);
    ready_i = r;
    #1;
    chk("yumi", int'(yumi_o), int'(ey));
    chk("valid", int'(valid_o), int'(ev));
    if (ev) begin
      chk("sb_nonempty", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        chk("total", int'(data_o), exp_q[0]);
        if (r) void'(exp_q.pop_front());
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rst_cycle();
    reset_i = 1'b1;
    valid_i = 1'b1;
    data_i  = 10'd7;
    ready_i = 1'b1;
    #1;
    chk("rst_yumi", int'(yumi_o), 0);
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_data", int'(data_o), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    valid2 = 1'b0;
    data2  = '0;
    ready2 = 1'b1;

    // reset held with valid_i high
    repeat (3) rst_cycle();
    reset_i = 1'b0;

    // basic group
    exp_q.push_back(10);
    step(1, 1, 1, 1, 0);
    step(1, 2, 1, 1, 0);
    step(1, 3, 1, 1, 0);
    step(1, 4, 1, 1, 0);
    step(0, 0, 1, 0, 1);
    step(0, 0, 1, 0, 0);

    // backpressure, then zero-bubble restart
    exp_q.push_back(26);
    step(1, 5, 0, 1, 0);
    step(1, 6, 0, 1, 0);
    step(1, 7, 0, 1, 0);
    step(1, 8, 0, 1, 0);
    step(1, 9, 0, 0, 1);
    step(1, 9, 0, 0, 1);
    exp_q.push_back(12);
    step(1, 9, 1, 1, 1);
    step(1, 1, 1, 1, 0);
    step(0, 0, 1, 0, 0);
    step(1, 1, 1, 1, 0);
    step(1, 1, 1, 1, 0);
    step(0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 0);

    // reset mid-group discards partial sum
    step(1, 100, 1, 1, 0);
    step(1, 200, 1, 1, 0);
    rst_cycle();
    reset_i = 1'b0;
    exp_q.push_back(4);
    step(1, 1, 1, 1, 0);
    step(1, 1, 1, 1, 0);
    step(1, 1, 1, 1, 0);
    step(1, 1, 1, 1, 0);
    step(0, 0, 1, 0, 1);
    chk("sb_drained", exp_q.size(), 0);

    // overflow on 11-bit sum
    valid_i = 1'b0;
    valid2  = 1'b1;
    data2   = 10'd1023;
    ready2  = 1'b1;
    repeat (4) begin
      #1;
      chk("ovf_yumi", int'(yumi2), 1);
      @(posedge clk);
      #1;
    end
    valid2 = 1'b0;
    #1;
    chk("ovf_valid", int'(valid_o2), 1);
`ifdef ELASTIC_ACCUM_SATURATE_EN
    chk("ovf_sum", int'(data_o2), 2047);
`else
    chk("ovf_sum", int'(data_o2), 2044);
`endif
    @(posedge clk);
    #1;
    chk("ovf_done", int'(valid_o2), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
